// File: rtl/regfile_dump.sv
// Walks a register file read port from index 0 to RFILE_SIZE-1 and streams each
// value out over a valid/ready channel, one word per FETCH/SEND pair.
module regfile_dump #(
  parameter int RFILE_SIZE = 32,
  parameter int WORD_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rsel,
  input  logic [WORD_W-1:0] rdat,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [WORD_W-1:0] dump_data,
  output logic [4:0]        dump_idx,
  output logic              dump_last
);

  localparam int IDX_W = (RFILE_SIZE > 1) ? $clog2(RFILE_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RFILE_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [WORD_W-1:0]  data_reg;
  logic [IDX_W-1:0]   didx_reg;
  logic               last_reg;
  logic               fetch_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // The word is frozen here, so later register-file writes cannot disturb it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_reg <= '0;
      didx_reg <= '0;
      last_reg <= 1'b0;
    end else if (fetch_en) begin
      data_reg <= rdat;
      didx_reg <= idx_reg;
      last_reg <= (idx_reg == LAST_IDX);
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    busy       = (state_reg != IDLE);
    done       = 1'b0;
    dump_valid = 1'b0;
    rsel       = '0;
    fetch_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          idx_next   = '0;
        end
      end
      FETCH: begin
        rsel = 5'(idx_reg);
        if (abort) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          fetch_en   = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        // Abort outranks a handshake arriving in the same cycle.
        if (abort) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (dump_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            state_next = FETCH;
            idx_next   = idx_reg + 1'b1;
          end
        end
      end
      DONE: begin
        done       = ~abort;
        state_next = IDLE;
        idx_next   = '0;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign dump_data = data_reg;
  assign dump_idx  = 5'(didx_reg);
  assign dump_last = last_reg;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: stimulus pushes expected words, a negedge
// monitor pops and compares each presented word and checks it stays held.
module tb_regfile_dump;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dump_ready = 1'b1;
  logic        busy, done, dump_valid, dump_last;
  logic [4:0]  rsel, dump_idx;
  logic [31:0] rdat, dump_data;

  logic [31:0] regs [32];

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   seen = 0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   start_cyc = 0;
  int   exp_done = 0;

  regfile_dump #(.RFILE_SIZE(32), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .busy(busy), .done(done), .rsel(rsel), .rdat(rdat),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_idx(dump_idx), .dump_last(dump_last)
  );

  assign rdat = regs[rsel];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: one pop per presented word, hold checks while stalled.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dump_valid === 1'b1) begin
      if (!seen) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got idx %0d data 0x%0h, expected no word", dump_idx, dump_data);
        end else begin
          cur = q.pop_front();
          chk("word_idx", 64'(dump_idx), 64'(cur.idx));
          chk("word_data", 64'(dump_data), 64'(cur.data));
          chk("word_last", 64'(dump_last), 64'(cur.last));
        end
        seen = 1;
      end else begin
        chk("hold_idx", 64'(dump_idx), 64'(cur.idx));
        chk("hold_data", 64'(dump_data), 64'(cur.data));
      end
      if (dump_ready && !abort && !RST) seen = 0;
    end else begin
      seen = 0;
    end
  end

  task automatic push_words(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx  = 5'(i);
      e.data = regs[i];
      e.last = (i == 31);
      q.push_back(e);
    end
  endtask

  task automatic do_start();
    @(posedge CLK); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int target = done_cnt + 1;
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done pulse within 400 cycles, expected one", name);
    end
  endtask

  task automatic wait_word(input int idx, output bit found);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge CLK); #1;
      if (dump_valid === 1'b1 && dump_idx == 5'(idx)) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_idx%0d: word not presented within 200 cycles", idx);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rsel"}, 64'(rsel), 64'd0);
    chk({tag, "_valid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_data"}, 64'(dump_data), 64'd0);
    chk({tag, "_idx"}, 64'(dump_idx), 64'd0);
    chk({tag, "_last"}, 64'(dump_last), 64'd0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk_zero_outputs("reset");
    RST = 1'b0;

    // Full dump with ready tied high: done 65 cycles after start sampled
    push_words(32);
    do_start();
    wait_done("full");
    exp_done++;
    chk("full_done_cycle", 64'(done_cyc - start_cyc), 64'd65);
    chk("full_done_count", 64'(done_cnt), 64'(exp_done));
    chk("full_busy_after", 64'(busy), 64'd0);

    // Backpressure: 7 stalled cycles on idx 3
    push_words(32);
    do_start();
    wait_word(3, found);
    dump_ready = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("bp_still_idx3", 64'(dump_idx), 64'd3);
    chk("bp_still_valid", 64'(dump_valid), 64'd1);
    @(posedge CLK); #1;
    dump_ready = 1'b1;
    wait_done("backpressure");
    exp_done++;
    chk("bp_done_cycle", 64'(done_cyc - start_cyc), 64'd72);

    // Snapshot: overwrite reg 10 while its word is held
    push_words(32);
    do_start();
    wait_word(10, found);
    dump_ready = 1'b0;
    regs[10] = 32'hDEADBEEF;
    repeat (3) @(posedge CLK);
    #1;
    dump_ready = 1'b1;
    wait_done("snapshot");
    exp_done++;
    push_words(32);
    chk("snap_new_value_queued", 64'(q[10].data), 64'hDEADBEEF);
    do_start();
    wait_done("snapshot2");
    exp_done++;
    chk("snap_done_count", 64'(done_cnt), 64'(exp_done));

    // Abort at idx 12 together with a handshake
    push_words(13);
    do_start();
    wait_word(12, found);
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(dump_valid), 64'd0);
    repeat (10) @(posedge CLK);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'(exp_done));
    push_words(32);
    do_start();
    wait_done("restart");
    exp_done++;
    chk("restart_done_cycle", 64'(done_cyc - start_cyc), 64'd65);

    // start pulsed while busy at idx 20 is ignored
    push_words(32);
    do_start();
    wait_word(20, found);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done("busy_start");
    exp_done++;
    chk("busy_start_done_cycle", 64'(done_cyc - start_cyc), 64'd65);
    repeat (80) @(posedge CLK);
    #1;
    chk("busy_start_one_done", 64'(done_cnt), 64'(exp_done));
    chk("busy_start_idle", 64'(busy), 64'd0);

    // Reset during SEND of idx 5
    push_words(6);
    do_start();
    wait_word(5, found);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk_zero_outputs("midreset");
    RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    chk("midreset_no_done", 64'(done_cnt), 64'(exp_done));
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
